// File: rtl/mag_pkg.sv
// Shared constants and FSM state type for the gradient-magnitude scheduler.
package mag_pkg;
  localparam int SQ_W  = 17;
  localparam int MAG_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;
endpackage

// File: rtl/mag_sched_if.sv
// Bundle of requester, shared-unit and result signals for mag_sched.
interface mag_sched_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]                 req_valid;
  logic [N_REQ-1:0]                 req_ready;
  logic [N_REQ*mag_pkg::SQ_W-1:0]   req_sqrx;
  logic [N_REQ*mag_pkg::SQ_W-1:0]   req_sqry;
  logic [mag_pkg::SQ_W-1:0]         sq_x;
  logic [mag_pkg::SQ_W-1:0]         sq_y;
  logic [mag_pkg::MAG_W-1:0]        sq_mag;
  logic                             res_valid;
  logic                             res_ready;
  logic [mag_pkg::MAG_W-1:0]        res_mag;
  logic [ID_W-1:0]                  res_id;

  modport slave (
    input  req_valid, req_sqrx, req_sqry, sq_mag, res_ready,
    output req_ready, sq_x, sq_y, res_valid, res_mag, res_id
  );

  modport master (
    output req_valid, req_sqrx, req_sqry, sq_mag, res_ready,
    input  req_ready, sq_x, sq_y, res_valid, res_mag, res_id
  );
endinterface

// File: rtl/mag_rr_arb.sv
// Combinational one-hot grant over the requester valids.
// Define MAG_SCHED_FIXED_PRIO_EN for lowest-index-wins instead of round-robin.
module mag_rr_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]  last_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  gnt_idx_o,
  output logic             any_o
);
  logic [ID_W-1:0] cand;

`ifdef MAG_SCHED_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last_i;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'(k);
      if (!any_o && valid_i[cand]) begin
        any_o       = 1'b1;
        gnt_idx_o   = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end
`else
  // Search starts one past the previous winner so every valid requester is
  // reached within N_REQ grants.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(last_i) + k) % N_REQ);
      if (!any_o && valid_i[cand]) begin
        any_o       = 1'b1;
        gnt_idx_o   = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end
`endif
endmodule

// File: rtl/mag_sched.sv
// Shares one registered magnitude unit between N_REQ requesters; results
// return tagged with the requester id. Priority mode: MAG_SCHED_FIXED_PRIO_EN.
module mag_sched
  import mag_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input logic        clk,
  input logic        rst_n,
  mag_sched_if.slave bus
);
  logic [N_REQ-1:0][SQ_W-1:0] sqx_lane, sqy_lane;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign sqx_lane[i] = bus.req_sqrx[i*SQ_W +: SQ_W];
    assign sqy_lane[i] = bus.req_sqry[i*SQ_W +: SQ_W];
  end

  state_t           state_q, state_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [SQ_W-1:0]  sqx_q, sqx_d;
  logic [SQ_W-1:0]  sqy_q, sqy_d;
  logic [MAG_W-1:0] mag_q, mag_d;
  logic [N_REQ-1:0] gnt, rdy;
  logic [ID_W-1:0]  gnt_idx;
  logic             any_gnt, vld;

  mag_rr_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .valid_i   (bus.req_valid),
    .last_i    (last_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (any_gnt)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    sqx_d   = sqx_q;
    sqy_d   = sqy_q;
    mag_d   = mag_q;
    rdy     = '0;
    vld     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_gnt) begin
          rdy     = gnt;
          sqx_d   = sqx_lane[gnt_idx];
          sqy_d   = sqy_lane[gnt_idx];
          id_d    = gnt_idx;
          last_d  = gnt_idx;
          state_d = ST_ISSUE;
        end
      end
      // Shared unit samples sq_x/sq_y at the end of this cycle.
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        mag_d   = bus.sq_mag;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        vld = 1'b1;
        if (bus.res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= ID_W'(N_REQ - 1);
      id_q    <= '0;
      sqx_q   <= '0;
      sqy_q   <= '0;
      mag_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      sqx_q   <= sqx_d;
      sqy_q   <= sqy_d;
      mag_q   <= mag_d;
    end
  end

  assign bus.req_ready = rdy;
  assign bus.res_valid = vld;
  assign bus.sq_x      = sqx_q;
  assign bus.sq_y      = sqy_q;
  assign bus.res_mag   = mag_q;
  assign bus.res_id    = id_q;
endmodule

// File: tb/tb_mag_sched.sv
// Bench for mag_sched: transaction-level model of grant order and result
// timing, plus directed literal checks and a randomized phase.
module tb_mag_sched;
  import mag_pkg::*;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mag_sched_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

  mag_sched #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic int isqrt(int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Stand-in for the shared unit: one-cycle registered magnitude.
  always @(posedge clk) bus.sq_mag <= MAG_W'(isqrt(int'(bus.sq_x) + int'(bus.sq_y)));

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  bit m_pending = 0;
  int m_due, m_id, m_mag, m_last = N_REQ - 1;
  int exp_sqx = 0, exp_sqy = 0;
  logic [N_REQ-1:0] acc = '0, dut_rdy = '0;
  int gid[$], gcyc[$];

  task automatic cmp(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int pick(logic [N_REQ-1:0] v);
`ifdef MAG_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N_REQ; k++) if (v[(m_last + k) % N_REQ]) return (m_last + k) % N_REQ;
`endif
    return -1;
  endfunction

  task automatic check_cycle();
    logic [N_REQ-1:0] exp_rdy;
    bit exp_v;
    int g;
    dut_rdy = bus.req_ready;
    if (!rst_n) begin
      cmp("rst_rdy_vld", {bus.req_ready, bus.res_valid}, 0);
      cmp("rst_sq_x", bus.sq_x, 0);
      cmp("rst_sq_y", bus.sq_y, 0);
      cmp("rst_res_mag", bus.res_mag, 0);
      cmp("rst_res_id", bus.res_id, 0);
      m_pending = 0; m_last = N_REQ - 1; exp_sqx = 0; exp_sqy = 0; acc = '0;
      cyc++;
      return;
    end
    for (int i = 0; i < N_REQ; i++)
      if (bus.req_ready[i]) begin gid.push_back(i); gcyc.push_back(cyc); end
    exp_v = m_pending && (cyc >= m_due);
    cmp("res_valid", bus.res_valid, exp_v);
    if (exp_v) begin
      cmp("res_mag", bus.res_mag, m_mag);
      cmp("res_id", bus.res_id, m_id);
    end
    exp_rdy = '0;
    g = -1;
    if (!m_pending && bus.req_valid != '0) begin
      g = pick(bus.req_valid);
      exp_rdy[g] = 1'b1;
    end
    cmp("req_ready", bus.req_ready, exp_rdy);
    cmp("sq_x", bus.sq_x, exp_sqx);
    cmp("sq_y", bus.sq_y, exp_sqy);
    if (exp_v && bus.res_ready) m_pending = 0;
    acc = exp_rdy;
    if (g >= 0) begin
      m_pending = 1;
      m_due = cyc + 3;
      m_id = g;
      m_last = g;
      exp_sqx = int'(bus.req_sqrx[g*SQ_W +: SQ_W]);
      exp_sqy = int'(bus.req_sqry[g*SQ_W +: SQ_W]);
      m_mag = isqrt(exp_sqx + exp_sqy);
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~acc;
  endtask

  task automatic set_req(int i, int x, int y);
    bus.req_sqrx[i*SQ_W +: SQ_W] = SQ_W'(x);
    bus.req_sqry[i*SQ_W +: SQ_W] = SQ_W'(y);
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    repeat (6) step();
  endtask

  int dc, hs, n0;
  initial begin
    bus.req_valid = '0; bus.req_sqrx = '0; bus.req_sqry = '0; bus.res_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    do_reset();

    // Single request from requester 2: 9+16 -> 5
    bus.res_ready = 1'b1;
    set_req(2, 9, 16);
    step();
    cmp("t1_req_ready", dut_rdy, 4);
    step(); step();
    cmp("t1_res_valid", bus.res_valid, 1);
    cmp("t1_res_mag", bus.res_mag, 5);
    cmp("t1_res_id", bus.res_id, 2);
    step();
    drain();

    // All contenders held valid: grant order and spacing
    do_reset();
    gid.delete(); gcyc.delete();
    for (int s = 0; s < 20; s++) begin
`ifdef MAG_SCHED_FIXED_PRIO_EN
      if (!bus.req_valid[0]) set_req(0, $urandom_range(0, 131071), $urandom_range(0, 131071));
      if (!bus.req_valid[3]) set_req(3, $urandom_range(0, 131071), $urandom_range(0, 131071));
`else
      for (int i = 0; i < N_REQ; i++)
        if (!bus.req_valid[i]) set_req(i, $urandom_range(0, 131071), $urandom_range(0, 131071));
`endif
      step();
    end
    cmp("t2_ngrants", gid.size(), 5);
    for (int k = 0; k < 5 && k < gid.size(); k++) begin
`ifdef MAG_SCHED_FIXED_PRIO_EN
      cmp("t2_fixed_id", gid[k], 0);
`else
      cmp("t2_rr_id", gid[k], k % N_REQ);
`endif
      if (k > 0) cmp("t2_spacing", gcyc[k] - gcyc[k-1], 4);
    end
    drain();

    // Backpressure: 30000+40000 -> 264, held for 10 stalled cycles
    bus.res_ready = 1'b0;
    set_req(1, 30000, 40000);
    step(); step(); step();
    set_req(0, 7, 9);
    n0 = gid.size();
    repeat (10) step();
    cmp("t3_no_new_grant", gid.size(), n0);
    cmp("t3_res_valid", bus.res_valid, 1);
    cmp("t3_res_mag", bus.res_mag, 264);
    cmp("t3_res_id", bus.res_id, 1);
    bus.res_ready = 1'b1;
    hs = cyc;
    step(); step();
    cmp("t3_regrant_id", gid[$], 0);
    cmp("t3_regrant_cyc", gcyc[$], hs + 1);
    drain();

    // Reset asserted while the request is in WAIT
    set_req(3, 100, 0);
    step(); step();
    rst_n = 1'b0;
    #1;
    cmp("t4_async_vld", bus.res_valid, 0);
    cmp("t4_async_sqx", bus.sq_x, 0);
    cmp("t4_async_id", bus.res_id, 0);
    step(); step();
    rst_n = 1'b1;
    set_req(3, 100, 0);
    set_req(0, 4, 5);
    n0 = gid.size();
    step();
    cmp("t4_post_rst_grant", (gid.size() > n0) ? gid[$] : -1, 0);
    repeat (4) step();
    drain();

    // Request appears only in the DONE+res_ready cycle
    set_req(1, 1, 3);
    step();
    for (int k = 0; k < 10 && !(m_pending && cyc >= m_due); k++) step();
    cmp("t5_reached_done", int'(m_pending && cyc >= m_due), 1);
    set_req(0, 5, 4);
    dc = cyc;
    step(); step();
    cmp("t5_gnt_id", gid[$], 0);
    cmp("t5_gnt_cyc", gcyc[$], dc + 1);
    repeat (5) step();
    drain();

    // Randomized traffic with random backpressure
    for (int s = 0; s < 400; s++) begin
      for (int i = 0; i < N_REQ; i++)
        if (!bus.req_valid[i] && $urandom_range(0, 9) < 4)
          set_req(i, $urandom_range(0, 131071), $urandom_range(0, 131071));
      bus.res_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
